lcd_bus_responder: RTL and testbench
====================================

Name: lcd_bus_responder

Overview:
- Target-side model of the 8-bit parallel character-LCD bus driven by `display`: lcd_en, lcd_rs, lcd_rw, lcd_db, lcd_rst.
- Synchronises the bus, captures one transaction per falling edge of lcd_en, and decodes the HD44780-style instruction set.
- Maintains cursor and display state and a 2x16 DDRAM.
- Exposes state and a DDRAM read port to self-checking benches and on-chip loopback checks.

Parameters:
SYNC_STAGES, 2, synchroniser depth for lcd_* inputs (>=2)
CMD_CYCLES, 4, busy duration after any accepted write transaction
CLR_CYCLES, 80, busy duration after clear-display or return-home

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
lcd_en  input  1  bus strobe; transaction captured on falling edge
lcd_rs  input  1  0 = instruction, 1 = data
lcd_rw  input  1  0 = write, 1 = read
lcd_db  input  8  bus data
lcd_rst  input  1  LCD reset from driver, active-low
cmd_valid  output  1  one-cycle pulse: instruction write accepted
data_valid  output  1  one-cycle pulse: data write accepted
bus_byte  output  8  byte of last accepted transaction
cur_addr  output  7  DDRAM cursor address
disp_on  output  1  display-control D bit
cursor_on  output  1  display-control C bit
blink_on  output  1  display-control B bit
entry_inc  output  1  entry-mode I/D bit
busy  output  1  emulated busy flag
proto_err  output  1  one-cycle pulse on protocol violation
rd_idx  input  5  DDRAM index {line, col[3:0]}
rd_data  output  8  DDRAM byte at rd_idx, combinational

Behaviour:
- Reset (rst_n low, async):
  - All outputs 0 except entry_inc=1.
  - cur_addr=0x00, all DDRAM valid bits cleared.
- Synchronised lcd_rst low: same state as reset, applied synchronously; transactions ignored while low.
- Capture:
  - lcd_en, lcd_rs, lcd_rw, lcd_db each pass through SYNC_STAGES flops.
  - A falling edge is synchronised en 1 -> 0.
  - The transaction uses rs/rw/db synchronised values from the last cycle en was 1.
- Event timing: state update and cmd_valid/data_valid/proto_err pulse one clk after the edge is detected.
- Read transactions (rw=1): counted as nothing. No state change, no pulse, no error.
- Instruction write (rs=0, rw=0), decoded by highest set bit:
  - 0x01 clear: all valid bits cleared (reads then return 0x20); cur_addr=0; entry_inc=1; busy CLR_CYCLES.
  - 0x02-0x03 home: cur_addr=0; busy CLR_CYCLES.
  - 0x04-0x07 entry: entry_inc=db[1]; db[0] ignored.
  - 0x08-0x0F display control: disp_on=db[2], cursor_on=db[1], blink_on=db[0].
  - 0x10-0x1F shift:
    - db[3]=0: cursor moves right if db[2]=1, left otherwise, with line wrap.
    - db[3]=1: no change.
  - 0x20-0x3F function set: db[4]=0 (4-bit mode) -> proto_err pulse; otherwise accepted.
  - 0x40-0x7F CGRAM address: accepted, no state change.
  - 0x80-0xFF set DDRAM address: cur_addr={db[6],2'b00,db[3:0]}; if db[5:4]!=0, also proto_err.
- Data write (rs=1, rw=0):
  - DDRAM[{cur_addr[6],cur_addr[3:0]}]=db; valid bit set.
  - Cursor then advances per entry_inc.
- Cursor wrap:
  - Increment: 0x0F -> 0x40, 0x4F -> 0x00.
  - Decrement: 0x00 -> 0x4F, 0x40 -> 0x0F.
- Busy: every accepted write (not clear/home) sets busy for CMD_CYCLES cycles, starting the cycle after the event. A new accepted write reloads the counter.
- rd_data: stored byte if valid bit set, else 0x20.
- Simultaneous lcd_rst low and edge: reset wins; event dropped.
- Reset mid-busy: busy cleared immediately.

Optional Feature:
LCD_BUSY_EN
- Defined:
  - A write transaction captured while busy=1 is dropped: no state change, no valid pulse.
  - proto_err pulses.
- Undefined:
  - busy still reports timing.
  - Writes are always accepted regardless of busy; no busy-related proto_err.

Test Plan:
- Reset, then drive 0x38, 0x0C, 0x06, 0x01 as instructions (rs=0), each strobe 40 clk high/low -> disp_on=1, cursor_on=0, blink_on=0, entry_inc=1, cur_addr=0x00, four cmd_valid pulses, proto_err never.
- After init, data 0x48 then 0x69 -> rd_data(idx 0)=0x48, rd_data(idx 1)=0x69, cur_addr=0x02, two data_valid pulses with bus_byte 0x48 then 0x69.
- Instruction 0x8F, then data 0x41, 0x42 -> idx 15=0x41, idx 16=0x42, cur_addr=0x41. Then 0x04 and data 0x43 at cur_addr 0x41 -> cur_addr=0x40.
- Instruction 0x20 -> proto_err one pulse. Instruction 0xB0 -> proto_err pulse and cur_addr=0x00.
- Fill a cell, send 0x01 -> rd_data=0x20 for all 32 idx; busy high exactly 80 clk. With LCD_BUSY_EN, data write 10 clk after the clear edge -> proto_err, DDRAM unchanged.
- Pull lcd_rst low mid-transaction and async rst_n low mid-busy -> outputs at reset values, busy=0, the in-flight strobe produces no pulse.

Source files
------------

// File: rtl/lcd_bus_responder.sv
// Target-side model of an 8-bit HD44780-style character-LCD bus with a 2x16 DDRAM.
// Optional LCD_BUSY_EN: writes that arrive while busy are dropped and flagged as protocol errors.
module lcd_bus_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int CMD_CYCLES  = 4,
  parameter int CLR_CYCLES  = 80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_db,
  input  logic       lcd_rst,
  output logic       cmd_valid,
  output logic       data_valid,
  output logic [7:0] bus_byte,
  output logic [6:0] cur_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       busy,
  output logic       proto_err,
  input  logic [4:0] rd_idx,
  output logic [7:0] rd_data
);

  localparam int CNT_MAX = (CLR_CYCLES > CMD_CYCLES) ? CLR_CYCLES : CMD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // {lcd_rst, lcd_en, lcd_rs, lcd_rw, lcd_db} travel together through one synchroniser.
  logic [SYNC_STAGES-1:0][11:0] r_sync;
  logic       w_rst_s, w_en_s, w_rs_s, w_rw_s;
  logic [7:0] w_db_s;

  assign {w_rst_s, w_en_s, w_rs_s, w_rw_s, w_db_s} = r_sync[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], lcd_rst, lcd_en, lcd_rs, lcd_rw, lcd_db};
  end

  logic       r_en_d, r_rs_l, r_rw_l;
  logic [7:0] r_db_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_d <= 1'b0;
      r_rs_l <= 1'b0;
      r_rw_l <= 1'b0;
      r_db_l <= '0;
    end else begin
      r_en_d <= w_en_s;
      if (w_en_s) {r_rs_l, r_rw_l, r_db_l} <= {w_rs_s, w_rw_s, w_db_s};
    end
  end

  logic [6:0]    r_cur_addr;
  logic          r_disp_on, r_cursor_on, r_blink_on, r_entry_inc;
  logic          r_cmd_valid, r_data_valid, r_proto_err;
  logic [7:0]    r_bus_byte;
  logic [CW-1:0] r_busy_cnt;
  logic [31:0]   r_valid;
  logic [7:0]    r_mem [32];

  logic w_wr, w_drop, w_take, w_dl4;
  assign w_wr  = r_en_d & ~w_en_s & ~r_rw_l & w_rst_s;
  assign w_dl4 = ~r_rs_l & (r_db_l[7:4] == 4'b0010);
`ifdef LCD_BUSY_EN
  assign w_drop = w_wr & (r_busy_cnt != '0);
`else
  assign w_drop = 1'b0;
`endif
  assign w_take = w_wr & ~w_drop;

  // Cursor step with wrap between the two 16-column lines.
  function automatic logic [6:0] f_step(input logic [6:0] a, input logic inc);
    if (inc) f_step = (a[3:0] == 4'hF) ? {~a[6], 6'h00} : {a[6], 2'b00, a[3:0] + 4'd1};
    else     f_step = (a[3:0] == 4'h0) ? {~a[6], 2'b00, 4'hF} : {a[6], 2'b00, a[3:0] - 4'd1};
  endfunction

  logic [6:0]    w_nxt_addr;
  logic          w_nxt_disp, w_nxt_cursor, w_nxt_blink, w_nxt_inc;
  logic          w_nxt_cmd, w_nxt_data, w_nxt_err;
  logic [7:0]    w_nxt_byte;
  logic [CW-1:0] w_nxt_cnt;
  logic          w_clr_valid, w_mem_we;
  logic [4:0]    w_wr_idx;

  assign w_wr_idx = {r_cur_addr[6], r_cur_addr[3:0]};

  always_comb begin
    // NOTE: every combinational output is given a default first so no latch can be inferred.
    w_nxt_addr   = r_cur_addr;
    w_nxt_disp   = r_disp_on;
    w_nxt_cursor = r_cursor_on;
    w_nxt_blink  = r_blink_on;
    w_nxt_inc    = r_entry_inc;
    w_nxt_cmd    = 1'b0;
    w_nxt_data   = 1'b0;
    w_nxt_err    = 1'b0;
    w_nxt_byte   = r_bus_byte;
    w_nxt_cnt    = (r_busy_cnt != '0) ? r_busy_cnt - 1'b1 : r_busy_cnt;
    w_clr_valid  = 1'b0;
    w_mem_we     = 1'b0;

    if (w_drop || (w_take && w_dl4)) begin
      w_nxt_err = 1'b1;
    end else if (w_take) begin
      w_nxt_byte = r_db_l;
      w_nxt_cnt  = CW'(CMD_CYCLES);
      if (r_rs_l) begin
        w_mem_we   = 1'b1;
        w_nxt_data = 1'b1;
        w_nxt_addr = f_step(r_cur_addr, r_entry_inc);
      end else begin
        w_nxt_cmd = 1'b1;
        casez (r_db_l)
          8'b1???????: begin
            w_nxt_addr = {r_db_l[6], 2'b00, r_db_l[3:0]};
            w_nxt_err  = (r_db_l[5:4] != 2'b00);
          end
          8'b01??????, 8'b001?????: ;
          8'b0001????: if (!r_db_l[3]) w_nxt_addr = f_step(r_cur_addr, r_db_l[2]);
          8'b00001???: {w_nxt_disp, w_nxt_cursor, w_nxt_blink} = r_db_l[2:0];
          8'b000001??: w_nxt_inc = r_db_l[1];
          8'b0000001?: begin
            w_nxt_addr = '0;
            w_nxt_cnt  = CW'(CLR_CYCLES);
          end
          8'b00000001: begin
            w_clr_valid = 1'b1;
            w_nxt_addr  = '0;
            w_nxt_inc   = 1'b1;
            w_nxt_cnt   = CW'(CLR_CYCLES);
          end
          default: ;
        endcase
      end
    end

    // The driver's LCD reset overrides any event seen in the same cycle.
    if (!w_rst_s) begin
      w_nxt_addr   = '0;
      w_nxt_disp   = 1'b0;
      w_nxt_cursor = 1'b0;
      w_nxt_blink  = 1'b0;
      w_nxt_inc    = 1'b1;
      w_nxt_cmd    = 1'b0;
      w_nxt_data   = 1'b0;
      w_nxt_err    = 1'b0;
      w_nxt_byte   = '0;
      w_nxt_cnt    = '0;
      w_clr_valid  = 1'b1;
      w_mem_we     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_addr   <= '0;
      r_disp_on    <= 1'b0;
      r_cursor_on  <= 1'b0;
      r_blink_on   <= 1'b0;
      r_entry_inc  <= 1'b1;
      r_cmd_valid  <= 1'b0;
      r_data_valid <= 1'b0;
      r_proto_err  <= 1'b0;
      r_bus_byte   <= '0;
      r_busy_cnt   <= '0;
      r_valid      <= '0;
    end else begin
      r_cur_addr   <= w_nxt_addr;
      r_disp_on    <= w_nxt_disp;
      r_cursor_on  <= w_nxt_cursor;
      r_blink_on   <= w_nxt_blink;
      r_entry_inc  <= w_nxt_inc;
      r_cmd_valid  <= w_nxt_cmd;
      r_data_valid <= w_nxt_data;
      r_proto_err  <= w_nxt_err;
      r_bus_byte   <= w_nxt_byte;
      r_busy_cnt   <= w_nxt_cnt;
      if (w_clr_valid)   r_valid <= '0;
      else if (w_mem_we) r_valid[w_wr_idx] <= 1'b1;
    end
  end

  // NOTE: the byte array has no reset; the per-cell valid bits define what reads return.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_wr_idx] <= r_db_l;
  end

  assign cmd_valid  = r_cmd_valid;
  assign data_valid = r_data_valid;
  assign bus_byte   = r_bus_byte;
  assign cur_addr   = r_cur_addr;
  assign disp_on    = r_disp_on;
  assign cursor_on  = r_cursor_on;
  assign blink_on   = r_blink_on;
  assign entry_inc  = r_entry_inc;
  assign busy       = (r_busy_cnt != '0);
  assign proto_err  = r_proto_err;
  assign rd_data    = r_valid[rd_idx] ? r_mem[rd_idx] : 8'h20;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: table of bus transactions plus hand-written
// sequences for clear/busy timing, LCD reset mid-strobe and async reset mid-busy.
`timescale 1ns/1ps
module tb_lcd_bus_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_rst = 1'b1;
  logic [7:0] lcd_db = '0;
  logic       cmd_valid, data_valid, disp_on, cursor_on, blink_on, entry_inc, busy, proto_err;
  logic [7:0] bus_byte, rd_data;
  logic [6:0] cur_addr;
  logic [4:0] rd_idx = '0;

  always #5 clk = ~clk;

  lcd_bus_responder dut (
    .clk(clk), .rst_n(rst_n), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_db(lcd_db), .lcd_rst(lcd_rst), .cmd_valid(cmd_valid), .data_valid(data_valid),
    .bus_byte(bus_byte), .cur_addr(cur_addr), .disp_on(disp_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .entry_inc(entry_inc), .busy(busy), .proto_err(proto_err),
    .rd_idx(rd_idx), .rd_data(rd_data)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int n_cmd = 0, n_data = 0, n_err = 0;

  always @(negedge clk) begin
    if (cmd_valid === 1'b1)  n_cmd++;
    if (data_valid === 1'b1) n_data++;
    if (proto_err === 1'b1)  n_err++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic strobe_only(input logic rs, input logic rw, input logic [7:0] db, input int hold);
    @(negedge clk);
    lcd_rs = rs;
    lcd_rw = rw;
    lcd_db = db;
    lcd_en = 1'b1;
    repeat (hold) @(negedge clk);
    lcd_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({name, "_busy_timeout"}, (t < 300), 1);
  endtask

  task automatic bus_xfer(input logic rs, input logic rw, input logic [7:0] db, input string name);
    strobe_only(rs, rw, db, 40);
    repeat (40) @(negedge clk);
    wait_idle(name);
  endtask

  // Waits up to 20 cycles for busy to rise, then returns how many cycles it stayed high.
  task automatic measure_busy(output int len);
    int t = 0;
    len = 0;
    while (busy !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    while (busy === 1'b1 && len < 300) begin
      len++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic       rs;
    logic       rw;
    logic [7:0] db;
    logic [6:0] addr;
    logic [3:0] dcbi;   // {disp_on, cursor_on, blink_on, entry_inc}
    int         d_cmd;
    int         d_data;
    int         d_err;
    logic       chk_acc;
    logic [7:0] bb;
  } vec_t;

  function automatic vec_t mk(input logic rs, input logic rw, input logic [7:0] db,
                              input logic [6:0] addr, input logic [3:0] dcbi,
                              input int dc, input int dd, input int de,
                              input logic chk, input logic [7:0] bb);
    vec_t v;
    v.rs = rs; v.rw = rw; v.db = db; v.addr = addr; v.dcbi = dcbi;
    v.d_cmd = dc; v.d_data = dd; v.d_err = de; v.chk_acc = chk; v.bb = bb;
    return v;
  endfunction

  vec_t tbl[25];

  initial begin
    int c0, d0, e0, len, bad;
    string nm;
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    int c0, d0, e0, len, bad;
    //          rs rw db     addr   dcbi     cmd dat err chk bus_byte
    tbl[0]  = mk(0, 0, 8'h38, 7'h00, 4'b0001, 1, 0, 0, 1, 8'h38);
    tbl[1]  = mk(0, 0, 8'h0C, 7'h00, 4'b1001, 1, 0, 0, 1, 8'h0C);
    tbl[2]  = mk(0, 0, 8'h06, 7'h00, 4'b1001, 1, 0, 0, 1, 8'h06);
    tbl[3]  = mk(0, 0, 8'h01, 7'h00, 4'b1001, 1, 0, 0, 1, 8'h01);
    tbl[4]  = mk(1, 0, 8'h48, 7'h01, 4'b1001, 0, 1, 0, 1, 8'h48);
    tbl[5]  = mk(1, 0, 8'h69, 7'h02, 4'b1001, 0, 1, 0, 1, 8'h69);
    tbl[6]  = mk(0, 0, 8'h8F, 7'h0F, 4'b1001, 1, 0, 0, 1, 8'h8F);
    tbl[7]  = mk(1, 0, 8'h41, 7'h40, 4'b1001, 0, 1, 0, 1, 8'h41);
    tbl[8]  = mk(1, 0, 8'h42, 7'h41, 4'b1001, 0, 1, 0, 1, 8'h42);
    tbl[9]  = mk(0, 0, 8'h04, 7'h41, 4'b1000, 1, 0, 0, 1, 8'h04);
    tbl[10] = mk(1, 0, 8'h43, 7'h40, 4'b1000, 0, 1, 0, 1, 8'h43);
    tbl[11] = mk(0, 0, 8'h20, 7'h40, 4'b1000, 0, 0, 1, 0, 8'h00);
    tbl[12] = mk(0, 0, 8'hB0, 7'h00, 4'b1000, 1, 0, 1, 1, 8'hB0);
    tbl[13] = mk(0, 0, 8'h0F, 7'h00, 4'b1110, 1, 0, 0, 1, 8'h0F);
    tbl[14] = mk(0, 0, 8'h18, 7'h00, 4'b1110, 1, 0, 0, 1, 8'h18);
    tbl[15] = mk(0, 0, 8'h10, 7'h4F, 4'b1110, 1, 0, 0, 1, 8'h10);
    tbl[16] = mk(0, 0, 8'h14, 7'h00, 4'b1110, 1, 0, 0, 1, 8'h14);
    tbl[17] = mk(0, 0, 8'h07, 7'h00, 4'b1111, 1, 0, 0, 1, 8'h07);
    tbl[18] = mk(0, 0, 8'h4F, 7'h00, 4'b1111, 1, 0, 0, 1, 8'h4F);
    tbl[19] = mk(1, 1, 8'h55, 7'h00, 4'b1111, 0, 0, 0, 1, 8'h4F);
    tbl[20] = mk(0, 0, 8'hC5, 7'h45, 4'b1111, 1, 0, 0, 1, 8'hC5);
    tbl[21] = mk(1, 0, 8'h7A, 7'h46, 4'b1111, 0, 1, 0, 1, 8'h7A);
    tbl[22] = mk(0, 0, 8'h03, 7'h00, 4'b1111, 1, 0, 0, 1, 8'h03);
    tbl[23] = mk(0, 0, 8'h38, 7'h00, 4'b1111, 1, 0, 0, 1, 8'h38);
    tbl[24] = mk(0, 1, 8'h01, 7'h00, 4'b1111, 0, 0, 0, 1, 8'h38);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy_async", busy, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_flags", {disp_on, cursor_on, blink_on, entry_inc}, 4'b0001);
    check("rst_addr", cur_addr, 0);
    check("rst_byte_busy", {bus_byte, busy}, 0);
    rd_idx = 5'd5;
    #1 check("rst_rd_data", rd_data, 8'h20);

    for (int i = 0; i < 25; i++) begin
      c0 = n_cmd; d0 = n_data; e0 = n_err;
      bus_xfer(tbl[i].rs, tbl[i].rw, tbl[i].db, $sformatf("row%0d", i));
      check($sformatf("row%0d_addr", i), cur_addr, tbl[i].addr);
      check($sformatf("row%0d_dcbi", i), {disp_on, cursor_on, blink_on, entry_inc}, tbl[i].dcbi);
      check($sformatf("row%0d_err_pulses", i), n_err - e0, tbl[i].d_err);
      if (tbl[i].chk_acc) begin
        check($sformatf("row%0d_cmd_pulses", i), n_cmd - c0, tbl[i].d_cmd);
        check($sformatf("row%0d_data_pulses", i), n_data - d0, tbl[i].d_data);
        check($sformatf("row%0d_bus_byte", i), bus_byte, tbl[i].bb);
      end
    end

    rd_idx = 5'd0;  #1 check("ddram_0", rd_data, 8'h48);
    rd_idx = 5'd1;  #1 check("ddram_1", rd_data, 8'h69);
    rd_idx = 5'd2;  #1 check("ddram_2_empty", rd_data, 8'h20);
    rd_idx = 5'd15; #1 check("ddram_15", rd_data, 8'h41);
    rd_idx = 5'd16; #1 check("ddram_16", rd_data, 8'h42);
    rd_idx = 5'd17; #1 check("ddram_17", rd_data, 8'h43);
    rd_idx = 5'd21; #1 check("ddram_21", rd_data, 8'h7A);

    // Busy durations: ordinary write, then clear-display wiping the DDRAM
    bus_xfer(1, 0, 8'h5A, "fill");
    rd_idx = 5'd0; #1 check("fill_cell", rd_data, 8'h5A);
    strobe_only(0, 0, 8'h0C, 40);
    measure_busy(len);
    check("busy_len_cmd", len, 4);
    repeat (40) @(negedge clk);
    strobe_only(0, 0, 8'h01, 40);
    measure_busy(len);
    check("busy_len_clear", len, 80);
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      rd_idx = 5'(k);
      #1 if (rd_data !== 8'h20) bad++;
    end
    check("clear_all_cells_blank", bad, 0);
    check("clear_addr", cur_addr, 0);
    check("clear_entry_inc", entry_inc, 1);

`ifdef LCD_BUSY_EN
    bus_xfer(1, 0, 8'h66, "pre_busy_fill");
    c0 = n_cmd; d0 = n_data; e0 = n_err;
    strobe_only(0, 0, 8'h01, 4);
    repeat (10) @(negedge clk);
    strobe_only(1, 0, 8'h77, 4);
    repeat (40) @(negedge clk);
    wait_idle("busy_drop");
    check("busy_drop_err", n_err - e0, 1);
    check("busy_drop_data", n_data - d0, 0);
    rd_idx = 5'd0; #1 check("busy_drop_cell", rd_data, 8'h20);
    check("busy_drop_addr", cur_addr, 0);
`endif

    // LCD reset pulled low in the middle of a data strobe
    bus_xfer(0, 0, 8'h0F, "pre_lrst_disp");
    bus_xfer(1, 0, 8'h11, "pre_lrst_data");
    d0 = n_data;
    @(negedge clk);
    lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_db = 8'h99; lcd_en = 1'b1;
    repeat (10) @(negedge clk);
    lcd_rst = 1'b0;
    repeat (10) @(negedge clk);
    lcd_en = 1'b0;
    repeat (10) @(negedge clk);
    lcd_rst = 1'b1;
    repeat (10) @(negedge clk);
    check("lrst_no_data_pulse", n_data - d0, 0);
    check("lrst_flags", {disp_on, cursor_on, blink_on, entry_inc}, 4'b0001);
    check("lrst_addr_busy", {cur_addr, busy}, 0);
    check("lrst_bus_byte", bus_byte, 0);
    rd_idx = 5'd0; #1 check("lrst_cell_blank", rd_data, 8'h20);

    // Async reset during a long busy period
    bus_xfer(0, 0, 8'h0C, "pre_rst_disp");
    strobe_only(0, 0, 8'h01, 40);
    repeat (20) @(negedge clk);
    check("mid_busy_high", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_flags", {disp_on, cursor_on, blink_on, entry_inc}, 4'b0001);
    check("arst_addr", cur_addr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_arst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
